// File: rtl/uart_pkg.sv
// Shared UART definitions: error bit positions, line-format encodings, FIFO trigger
// encodings and the stored RX entry layout.
package uart_pkg;

    localparam int unsigned ERR_FRAME   = 2;
    localparam int unsigned ERR_PARITY  = 1;
    localparam int unsigned ERR_OVERRUN = 0;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ENTRY_W = 11;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } uart_parity_e;

    typedef enum logic [2:0] {
        DBITS_5 = 3'b000,
        DBITS_6 = 3'b001,
        DBITS_7 = 3'b010,
        DBITS_8 = 3'b011,
        DBITS_9 = 3'b100
    } uart_dbits_e;

    typedef enum logic [1:0] {
        TRIG_ONE     = 2'b00,
        TRIG_QUARTER = 2'b01,
        TRIG_HALF    = 2'b10,
        TRIG_NEAR    = 2'b11
    } uart_trig_e;

    typedef struct packed {
        logic              frame;
        logic              parity;
        logic              ovr;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    // Occupancy at which the data interrupt fires for a given trigger select.
    function automatic int unsigned trig_count(input logic [1:0] sel, input int unsigned depth);
        int unsigned n;
        case (uart_trig_e'(sel))
            TRIG_ONE:     n = 1;
            TRIG_QUARTER: n = depth / 4;
            TRIG_HALF:    n = depth / 2;
            default:      n = depth - 2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_sync_fifo_mem.sv
// DEPTH x W register array: synchronous write port, asynchronous read of the head.
module uart_sync_fifo_mem #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned W     = 11,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive buffer controller: FIFO / holding register, overrun, error and IRQ status.
// Optional character-timeout interrupt is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_success,
    input  logic [7:0]    rx_data,
    input  logic [2:0]    rx_error,
    input  logic          fifo_en,
    input  logic          flush,
    input  logic [1:0]    trig_sel,
    input  logic [23:0]   timeout_cycles,
    input  logic          rd_en,
    input  logic          ovr_clr,
    output logic [7:0]    rd_data,
    output logic [2:0]    rd_err,
    output logic          empty,
    output logic          fifo_full,
    output logic [AW:0]   level,
    output logic          overrun,
    output logic          err_pending,
    output logic          irq_data,
    output logic          irq_timeout
);

    localparam int unsigned LW = AW + 1;

    logic          fifo_en_q;
    logic          flush_pend_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] err_cnt_q;
    logic          ovr_mark_q;
    logic          overrun_q;
    logic          irq_data_q;

    logic [LW-1:0] cap;
    logic          full_int;
    logic          flush_any;
    logic          push_ok;
    logic          pop_ok;
    logic          drop;
    logic          push_err;
    logic          pop_err;
    logic [LW-1:0] level_nxt;
    logic          irq_data_nxt;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    rx_entry_t     wr_entry;
    rx_entry_t     head;
    logic [ENTRY_W-1:0] head_raw;

    // Capacity follows the registered mode so no input reaches an output combinationally.
    assign cap       = fifo_en_q ? LW'(DEPTH) : LW'(1);
    assign full_int  = (level_q >= cap);
    assign flush_any = flush | flush_pend_q;
    assign pop_ok    = !flush_any && rd_en && (level_q != '0);
    assign push_ok   = !flush_any && rx_success && (!full_int || pop_ok);
    assign drop      = !flush_any && rx_success && full_int && !pop_ok;
    assign push_err  = push_ok && (rx_error[ERR_FRAME] || rx_error[ERR_PARITY]);
    assign pop_err   = pop_ok && (head.frame || head.parity);

    assign wr_addr = fifo_en_q ? wr_ptr_q : '0;
    assign rd_addr = fifo_en_q ? rd_ptr_q : '0;

    always_comb begin
        wr_entry        = '0;
        wr_entry.frame  = rx_error[ERR_FRAME];
        wr_entry.parity = rx_error[ERR_PARITY];
        wr_entry.ovr    = ovr_mark_q;
        wr_entry.data   = rx_data;
    end

    always_comb begin
        level_nxt    = level_q;
        irq_data_nxt = 1'b0;
        if (flush_any) begin
            level_nxt = '0;
        end else begin
            level_nxt = level_q + LW'(push_ok) - LW'(pop_ok);
        end
        if (fifo_en_q) begin
            irq_data_nxt = (level_nxt >= LW'(trig_count(trig_sel, DEPTH)));
        end else begin
            irq_data_nxt = (level_nxt != '0);
        end
    end

    uart_sync_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_addr),
        .wdata (wr_entry),
        .raddr (rd_addr),
        .rdata (head_raw)
    );

    assign head = rx_entry_t'(head_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_en_q    <= fifo_en;
            flush_pend_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            err_cnt_q    <= '0;
            ovr_mark_q   <= 1'b0;
            overrun_q    <= 1'b0;
            irq_data_q   <= 1'b0;
        end else begin
            fifo_en_q    <= fifo_en;
            flush_pend_q <= (fifo_en != fifo_en_q);
            level_q      <= level_nxt;
            irq_data_q   <= irq_data_nxt;

            if (flush_any) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                err_cnt_q <= '0;
            end else begin
                if (push_ok && fifo_en_q) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop_ok && fifo_en_q) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (push_err && !pop_err) begin
                    err_cnt_q <= err_cnt_q + LW'(1);
                end else if (pop_err && !push_err) begin
                    err_cnt_q <= err_cnt_q - LW'(1);
                end
            end

            // Mark travels with the next accepted character, then re-arms.
            if (drop) begin
                ovr_mark_q <= 1'b1;
            end else if (push_ok) begin
                ovr_mark_q <= 1'b0;
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign level       = level_q;
    assign empty       = (level_q == '0);
    assign fifo_full   = (level_q == cap);
    assign overrun     = overrun_q;
    assign err_pending = (err_cnt_q != '0);
    assign irq_data    = irq_data_q;
    assign rd_data     = empty ? '0 : head.data;
    assign rd_err      = empty ? '0 : {head.frame, head.parity, head.ovr};

`ifdef UART_RX_TIMEOUT_EN
    logic [23:0] tmo_cnt_q;
    logic        irq_tmo_q;
    logic        activity;
    logic        unused_bits;

    assign activity    = push_ok | pop_ok | flush_any;
    assign unused_bits = rx_error[ERR_OVERRUN];

    // Idle countdown while data sits unread; a zero load disables the interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            irq_tmo_q <= 1'b0;
        end else begin
            if (activity || empty) begin
                tmo_cnt_q <= timeout_cycles;
            end else if (tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - 24'd1;
            end

            if (activity) begin
                irq_tmo_q <= 1'b0;
            end else if ((tmo_cnt_q == '0) && !empty && (timeout_cycles != '0)) begin
                irq_tmo_q <= 1'b1;
            end
        end
    end

    assign irq_timeout = irq_tmo_q;
`else
    logic unused_bits;

    assign unused_bits = rx_error[ERR_OVERRUN] ^ (^timeout_cycles);
    assign irq_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl: vector table plus hand-written
// overrun, holding-mode and timeout sequences.
module tb_uart_rx_fifo_ctrl;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_success;
    logic [7:0]    rx_data;
    logic [2:0]    rx_error;
    logic          fifo_en;
    logic          flush;
    logic [1:0]    trig_sel;
    logic [23:0]   timeout_cycles;
    logic          rd_en;
    logic          ovr_clr;
    logic [7:0]    rd_data;
    logic [2:0]    rd_err;
    logic          empty;
    logic          fifo_full;
    logic [AW:0]   level;
    logic          overrun;
    logic          err_pending;
    logic          irq_data;
    logic          irq_timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo_ctrl #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_success     (rx_success),
        .rx_data        (rx_data),
        .rx_error       (rx_error),
        .fifo_en        (fifo_en),
        .flush          (flush),
        .trig_sel       (trig_sel),
        .timeout_cycles (timeout_cycles),
        .rd_en          (rd_en),
        .ovr_clr        (ovr_clr),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .empty          (empty),
        .fifo_full      (fifo_full),
        .level          (level),
        .overrun        (overrun),
        .err_pending    (err_pending),
        .irq_data       (irq_data),
        .irq_timeout    (irq_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [7:0]  d;
        logic [2:0]  e;
        logic        pop;
        logic        fl;
        logic [4:0]  lvl;
        logic        emp;
        logic [7:0]  rd;
        logic [2:0]  rerr;
        logic        irq;
        logic        errp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are then stable and pulse inputs are dropped.
    task automatic cyc();
        @(posedge clk);
        #1;
        rx_success = 1'b0;
        rd_en      = 1'b0;
        flush      = 1'b0;
        ovr_clr    = 1'b0;
        rx_error   = 3'b000;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        rx_success = 1'b1;
        rx_data    = d;
        rx_error   = e;
        cyc();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        cyc();
    endtask

    initial begin
        rst            = 1'b1;
        rx_success     = 1'b0;
        rx_data        = 8'h00;
        rx_error       = 3'b000;
        fifo_en        = 1'b1;
        flush          = 1'b0;
        trig_sel       = 2'b01;
        timeout_cycles = 24'd100;
        rd_en          = 1'b0;
        ovr_clr        = 1'b0;

        //          push  d      e       pop   fl   lvl   emp  rd     rerr    irq  errp
        vecs[0]  = '{1'b1, 8'h41, 3'b000, 1'b0, 1'b0, 5'd1, 1'b0, 8'h41, 3'b000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h42, 3'b000, 1'b0, 1'b0, 5'd2, 1'b0, 8'h41, 3'b000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h43, 3'b000, 1'b0, 1'b0, 5'd3, 1'b0, 8'h41, 3'b000, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 3'b000, 1'b0, 1'b0, 5'd4, 1'b0, 8'h41, 3'b000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd3, 1'b0, 8'h42, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd2, 1'b0, 8'h43, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd1, 1'b0, 8'h44, 3'b000, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h50, 3'b000, 1'b1, 1'b0, 5'd1, 1'b0, 8'h50, 3'b000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h10, 3'b100, 1'b0, 1'b0, 5'd1, 1'b0, 8'h10, 3'b100, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 8'h11, 3'b000, 1'b0, 1'b0, 5'd2, 1'b0, 8'h10, 3'b100, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 8'h12, 3'b010, 1'b1, 1'b0, 5'd2, 1'b0, 8'h11, 3'b000, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd1, 1'b0, 8'h12, 3'b010, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 5'd0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 8'h20, 3'b000, 1'b0, 1'b1, 5'd0, 1'b1, 8'h00, 3'b000, 1'b0, 1'b0};

        repeat (3) cyc();
        rst = 1'b0;

        chk("rst_empty",   32'(empty),       32'd1);
        chk("rst_full",    32'(fifo_full),   32'd0);
        chk("rst_level",   32'(level),       32'd0);
        chk("rst_rd_data", 32'(rd_data),     32'd0);
        chk("rst_rd_err",  32'(rd_err),      32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        chk("rst_errp",    32'(err_pending), 32'd0);
        chk("rst_irq",     32'(irq_data),    32'd0);
        chk("rst_irq_tmo", 32'(irq_timeout), 32'd0);

        for (int i = 0; i < 17; i++) begin
            rx_success = vecs[i].push;
            rx_data    = vecs[i].d;
            rx_error   = vecs[i].e;
            rd_en      = vecs[i].pop;
            flush      = vecs[i].fl;
            cyc();
            chk($sformatf("v%0d_level", i),   32'(level),       32'(vecs[i].lvl));
            chk($sformatf("v%0d_empty", i),   32'(empty),       32'(vecs[i].emp));
            chk($sformatf("v%0d_full", i),    32'(fifo_full),   32'd0);
            chk($sformatf("v%0d_rd_data", i), 32'(rd_data),     32'(vecs[i].rd));
            chk($sformatf("v%0d_rd_err", i),  32'(rd_err),      32'(vecs[i].rerr));
            chk($sformatf("v%0d_irq", i),     32'(irq_data),    32'(vecs[i].irq));
            chk($sformatf("v%0d_errp", i),    32'(err_pending), 32'(vecs[i].errp));
            chk($sformatf("v%0d_ovr", i),     32'(overrun),     32'd0);
        end

        // Fill to capacity back-to-back, then overrun.
        for (int i = 0; i < 16; i++) push(8'(i), 3'b000);
        chk("fill_level", 32'(level),     32'd16);
        chk("fill_full",  32'(fifo_full), 32'd1);
        chk("fill_irq",   32'(irq_data),  32'd1);
        chk("fill_head",  32'(rd_data),   32'h00);
        push(8'h55, 3'b000);
        chk("ovr_set",   32'(overrun), 32'd1);
        chk("ovr_level", 32'(level),   32'd16);
        chk("ovr_head",  32'(rd_data), 32'h00);
        pop();
        chk("ovr_pop_level", 32'(level),   32'd15);
        chk("ovr_pop_head",  32'(rd_data), 32'h01);
        push(8'h66, 3'b000);
        chk("refill_level", 32'(level), 32'd16);
        ovr_clr = 1'b1;
        cyc();
        chk("ovr_clr", 32'(overrun), 32'd0);
        rx_success = 1'b1;
        rx_data    = 8'h77;
        rd_en      = 1'b1;
        cyc();
        chk("pushpop_full_level", 32'(level),   32'd16);
        chk("pushpop_full_ovr",   32'(overrun), 32'd0);
        chk("pushpop_full_head",  32'(rd_data), 32'h02);
        for (int i = 0; i < 14; i++) pop();
        chk("mark_data", 32'(rd_data), 32'h66);
        chk("mark_err",  32'(rd_err),  32'b001);
        pop();
        chk("after_mark_data", 32'(rd_data), 32'h77);
        chk("after_mark_err",  32'(rd_err),  32'b000);
        pop();
        chk("drain_empty", 32'(empty), 32'd1);

        // Trigger level 1 in FIFO mode.
        trig_sel = 2'b00;
        push(8'h01, 3'b000);
        chk("trig1_irq", 32'(irq_data), 32'd1);
        pop();
        chk("trig1_irq_off", 32'(irq_data), 32'd0);
        trig_sel = 2'b01;

        // Holding-register mode.
        fifo_en = 1'b0;
        cyc();
        cyc();
        push(8'hA5, 3'b000);
        chk("hold_full",  32'(fifo_full), 32'd1);
        chk("hold_level", 32'(level),     32'd1);
        chk("hold_data",  32'(rd_data),   32'hA5);
        chk("hold_irq",   32'(irq_data),  32'd1);
        push(8'h5A, 3'b000);
        chk("hold_ovr",      32'(overrun), 32'd1);
        chk("hold_ovr_data", 32'(rd_data), 32'hA5);
        ovr_clr = 1'b1;
        cyc();
        chk("hold_ovr_clr", 32'(overrun), 32'd0);
        ovr_clr = 1'b1;
        push(8'h33, 3'b000);
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        chk("ovr_set_data", 32'(rd_data), 32'hA5);
        fifo_en = 1'b1;
        cyc();
        chk("mode_chg_1", 32'(empty), 32'd0);
        cyc();
        chk("mode_chg_2", 32'(empty), 32'd1);
        chk("mode_chg_ovr", 32'(overrun), 32'd1);

        // Character timeout; the pending overrun mark rides on this entry.
        push(8'h99, 3'b000);
        chk("tmo_entry_err", 32'(rd_err), 32'b001);
`ifdef UART_RX_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!irq_timeout && n < 200) begin
                cyc();
                n++;
            end
            chk("tmo_cycles", 32'(n), 32'd101);
        end
        pop();
        chk("tmo_clear", 32'(irq_timeout), 32'd0);
`else
        repeat (150) cyc();
        chk("tmo_disabled", 32'(irq_timeout), 32'd0);
        pop();
`endif
        chk("tmo_end_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
